// File: rtl/sc_level_shift_ctrl_pkg.sv
// Shared definitions for the level/shift controller slice.
//   - FSM state encoding
//   - background-register shift codes
//   - level codes and tick-counter width
//   - helper that maps a level index onto its tick period
package sc_level_shift_ctrl_pkg;

    localparam int CNT_W = 24;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_RUN     = 3'd2,
        ST_ADVANCE = 3'd3,
        ST_OVER    = 3'd4,
        ST_WON     = 3'd5
    } state_t;

    localparam logic [1:0] SHIFT_NONE  = 2'b00;
    localparam logic [1:0] SHIFT_LEFT  = 2'b01;
    localparam logic [1:0] SHIFT_RIGHT = 2'b10;

    localparam logic [1:0] LEVEL_0 = 2'd0;
    localparam logic [1:0] LEVEL_1 = 2'd1;
    localparam logic [1:0] LEVEL_2 = 2'd2;
    localparam logic [1:0] LEVEL_3 = 2'd3;

    function automatic logic [CNT_W-1:0] sel_period(
        input logic [1:0]       lvl,
        input logic [CNT_W-1:0] p1,
        input logic [CNT_W-1:0] p2,
        input logic [CNT_W-1:0] p3,
        input logic [CNT_W-1:0] p4
    );
        logic [CNT_W-1:0] p;
        case (lvl)
            LEVEL_0: p = p1;
            LEVEL_1: p = p2;
            LEVEL_2: p = p3;
            default: p = p4;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/sc_level_shift_ctrl_if.sv
// Game-side bundle of the level/shift controller.
//   master : game logic / stimulus (drives start, win, lose, pause)
//   slave  : the controller (drives level, clear, load, shift code, status)
interface sc_level_shift_ctrl_if;

    logic       SC_LevelShiftCtrl_start_InLow;
    logic       SC_LevelShiftCtrl_win_InLow;
    logic       SC_LevelShiftCtrl_lose_InLow;
    logic       SC_LevelShiftCtrl_pause_InLow;
    logic [1:0] SC_LevelShiftCtrl_level_OutBUS;
    logic       SC_LevelShiftCtrl_clear_OutLow;
    logic       SC_LevelShiftCtrl_load_OutLow;
    logic [1:0] SC_LevelShiftCtrl_shiftselection_Out;
    logic       SC_LevelShiftCtrl_gameover_OutHigh;
    logic       SC_LevelShiftCtrl_gamewon_OutHigh;

    modport master (
        output SC_LevelShiftCtrl_start_InLow,
        output SC_LevelShiftCtrl_win_InLow,
        output SC_LevelShiftCtrl_lose_InLow,
        output SC_LevelShiftCtrl_pause_InLow,
        input  SC_LevelShiftCtrl_level_OutBUS,
        input  SC_LevelShiftCtrl_clear_OutLow,
        input  SC_LevelShiftCtrl_load_OutLow,
        input  SC_LevelShiftCtrl_shiftselection_Out,
        input  SC_LevelShiftCtrl_gameover_OutHigh,
        input  SC_LevelShiftCtrl_gamewon_OutHigh
    );

    modport slave (
        input  SC_LevelShiftCtrl_start_InLow,
        input  SC_LevelShiftCtrl_win_InLow,
        input  SC_LevelShiftCtrl_lose_InLow,
        input  SC_LevelShiftCtrl_pause_InLow,
        output SC_LevelShiftCtrl_level_OutBUS,
        output SC_LevelShiftCtrl_clear_OutLow,
        output SC_LevelShiftCtrl_load_OutLow,
        output SC_LevelShiftCtrl_shiftselection_Out,
        output SC_LevelShiftCtrl_gameover_OutHigh,
        output SC_LevelShiftCtrl_gamewon_OutHigh
    );

endinterface

// File: rtl/sc_shift_tick.sv
// Period counter that produces a one-cycle tick every i_period enabled cycles.
//   i_clk     clock (rising edge)
//   i_srst    synchronous active-high reset
//   i_clear   synchronous counter clear (wins over enable)
//   i_enable  count enable; counter holds when low
//   i_period  tick period in enabled cycles (legal 2..2^24-1)
//   o_tick    high in the cycle whose edge wraps the counter to zero
module sc_shift_tick
    import sc_level_shift_ctrl_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_srst,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [CNT_W-1:0] i_period,
    output logic             o_tick
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_end;

    assign w_at_end = (r_cnt == CNT_W'(i_period - CNT_W'(1)));
    assign o_tick   = i_enable && w_at_end;

    always_ff @(posedge i_clk) begin
        if (i_srst || i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            if (w_at_end) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/sc_level_shift_ctrl.sv
// Frogger-style level/shift controller. Sequences IDLE -> LOAD -> RUN, issues
// a periodic shift code to the background register whose period depends on
// the current level, and moves through ADVANCE / OVER / WON on win and lose.
//   SC_LevelShiftCtrl_CLOCK_50      clock (rising edge)
//   SC_LevelShiftCtrl_RESET_InHigh  synchronous active-high reset
//   io_bus                          game-side bundle (slave modport)
// All outputs are registered.
module sc_level_shift_ctrl
    import sc_level_shift_ctrl_pkg::*;
#(
    parameter logic [23:0] TICKS_L1  = 24'd5000000,
    parameter logic [23:0] TICKS_L2  = 24'd3750000,
    parameter logic [23:0] TICKS_L3  = 24'd2500000,
    parameter logic [23:0] TICKS_L4  = 24'd1250000,
    parameter logic [1:0]  SHIFT_DIR = SHIFT_LEFT
)(
    input  logic                  SC_LevelShiftCtrl_CLOCK_50,
    input  logic                  SC_LevelShiftCtrl_RESET_InHigh,
    sc_level_shift_ctrl_if.slave  io_bus
);

    state_t           r_state;
    logic [1:0]       r_level;
    logic             r_clear_n;
    logic             r_load_n;
    logic [1:0]       r_shift;
    logic             r_over;
    logic             r_won;

    logic             w_start;
    logic             w_win;
    logic             w_lose;
    logic             w_run_free;
    logic [CNT_W-1:0] w_period;
    logic             w_tick;

    assign w_start = ~io_bus.SC_LevelShiftCtrl_start_InLow;
    assign w_win   = ~io_bus.SC_LevelShiftCtrl_win_InLow;
    assign w_lose  = ~io_bus.SC_LevelShiftCtrl_lose_InLow;

    // Counting only happens in RUN when nothing of higher priority is active;
    // a win or lose leaves RUN anyway, and the counter is cleared on re-entry.
    assign w_run_free = (r_state == ST_RUN) && io_bus.SC_LevelShiftCtrl_pause_InLow
                        && !w_win && !w_lose;
    assign w_period   = sel_period(r_level, TICKS_L1, TICKS_L2, TICKS_L3, TICKS_L4);

    sc_shift_tick u_tick (
        .i_clk    (SC_LevelShiftCtrl_CLOCK_50),
        .i_srst   (SC_LevelShiftCtrl_RESET_InHigh),
        .i_clear  (r_state != ST_RUN),
        .i_enable (w_run_free),
        .i_period (w_period),
        .o_tick   (w_tick)
    );

    // Outputs are assigned alongside the transition so that each registered
    // output already carries the value belonging to the state being entered.
    always_ff @(posedge SC_LevelShiftCtrl_CLOCK_50) begin
        if (SC_LevelShiftCtrl_RESET_InHigh) begin
            r_state   <= ST_IDLE;
            r_level   <= LEVEL_0;
            r_clear_n <= 1'b0;
            r_load_n  <= 1'b1;
            r_shift   <= SHIFT_NONE;
            r_over    <= 1'b0;
            r_won     <= 1'b0;
        end else begin
            r_clear_n <= 1'b1;
            r_load_n  <= 1'b1;
            r_shift   <= SHIFT_NONE;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state  <= ST_LOAD;
                        r_load_n <= 1'b0;
                    end else begin
                        r_clear_n <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (w_lose) begin
                        r_state <= ST_OVER;
                        r_over  <= 1'b1;
                    end else if (w_win) begin
                        if (r_level != LEVEL_3) begin
                            r_state <= ST_ADVANCE;
                            r_level <= r_level + 2'd1;
                        end else begin
                            r_state <= ST_WON;
                            r_won   <= 1'b1;
                        end
                    end else if (w_tick) begin
                        r_shift <= SHIFT_DIR;
                    end
                end
                ST_ADVANCE: begin
                    r_state  <= ST_LOAD;
                    r_load_n <= 1'b0;
                end
                ST_OVER, ST_WON: begin
                    if (w_start) begin
                        r_state  <= ST_LOAD;
                        r_load_n <= 1'b0;
                        r_level  <= LEVEL_0;
                        r_over   <= 1'b0;
                        r_won    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign io_bus.SC_LevelShiftCtrl_level_OutBUS       = r_level;
    assign io_bus.SC_LevelShiftCtrl_clear_OutLow       = r_clear_n;
    assign io_bus.SC_LevelShiftCtrl_load_OutLow        = r_load_n;
    assign io_bus.SC_LevelShiftCtrl_shiftselection_Out = r_shift;
    assign io_bus.SC_LevelShiftCtrl_gameover_OutHigh   = r_over;
    assign io_bus.SC_LevelShiftCtrl_gamewon_OutHigh    = r_won;

endmodule

// File: tb/tb_sc_level_shift_ctrl.sv
// Directed bench for sc_level_shift_ctrl with periods 4,3,2,2 and left shift.
// Inputs change 1 time unit after each rising edge; outputs are observed at
// that same point, so each cyc() call looks at the cycle that just began.
module tb_sc_level_shift_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    sc_level_shift_ctrl_if bus ();

    sc_level_shift_ctrl #(
        .TICKS_L1  (24'd4),
        .TICKS_L2  (24'd3),
        .TICKS_L3  (24'd2),
        .TICKS_L4  (24'd2),
        .SHIFT_DIR (2'b01)
    ) dut (
        .SC_LevelShiftCtrl_CLOCK_50     (clk),
        .SC_LevelShiftCtrl_RESET_InHigh (rst),
        .io_bus                         (bus)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_state(input string tag, input logic [1:0] lvl, input logic clr_n,
                             input logic load_n, input logic over, input logic won);
        chk({tag, ".level"}, bus.SC_LevelShiftCtrl_level_OutBUS, lvl);
        chk({tag, ".clear"}, bus.SC_LevelShiftCtrl_clear_OutLow, clr_n);
        chk({tag, ".load"},  bus.SC_LevelShiftCtrl_load_OutLow, load_n);
        chk({tag, ".shift"}, bus.SC_LevelShiftCtrl_shiftselection_Out, 2'b00);
        chk({tag, ".over"},  bus.SC_LevelShiftCtrl_gameover_OutHigh, over);
        chk({tag, ".won"},   bus.SC_LevelShiftCtrl_gamewon_OutHigh, won);
    endtask

    // Observe ncyc RUN cycles (k = 0 is the first RUN cycle); a pulse is
    // expected at k = first, first+period, ...
    task automatic run_shifts(input string tag, input int ncyc, input int first, input int period);
        logic [1:0] exp;
        for (int k = 0; k < ncyc; k++) begin
            cyc();
            exp = (k >= first && ((k - first) % period) == 0) ? 2'b01 : 2'b00;
            $display("%s k=%0d shift=%b exp=%b", tag, k, bus.SC_LevelShiftCtrl_shiftselection_Out, exp);
            chk($sformatf("%s.k%0d", tag, k), bus.SC_LevelShiftCtrl_shiftselection_Out, exp);
            chk($sformatf("%s.ld%0d", tag, k), bus.SC_LevelShiftCtrl_load_OutLow, 1'b1);
        end
    endtask

    initial begin
        bus.SC_LevelShiftCtrl_start_InLow = 1'b1;
        bus.SC_LevelShiftCtrl_win_InLow   = 1'b1;
        bus.SC_LevelShiftCtrl_lose_InLow  = 1'b1;
        bus.SC_LevelShiftCtrl_pause_InLow = 1'b1;

        // Reset state
        cyc(); cyc();
        chk_state("reset", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        cyc();
        chk_state("idle", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Start: one-cycle load, then period-4 shifts
        bus.SC_LevelShiftCtrl_start_InLow = 1'b0;
        cyc();
        bus.SC_LevelShiftCtrl_start_InLow = 1'b1;
        chk_state("load0", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        run_shifts("run_l0", 11, 4, 4);            // k=10: counter = 2

        // Pause for 10 edges at counter 2; next pulse 2 cycles after release
        bus.SC_LevelShiftCtrl_pause_InLow = 1'b0;
        run_shifts("pause", 10, 100, 1);
        bus.SC_LevelShiftCtrl_pause_InLow = 1'b1;
        run_shifts("resume", 6, 1, 4);             // last cycle: counter = 0

        // Wins at levels 0,1,2 with periods 3 and 2
        bus.SC_LevelShiftCtrl_win_InLow = 1'b0;
        cyc();
        bus.SC_LevelShiftCtrl_win_InLow = 1'b1;
        chk_state("adv1", 2'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc();
        chk_state("load1", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        run_shifts("run_l1", 7, 3, 3);
        bus.SC_LevelShiftCtrl_win_InLow = 1'b0;
        cyc();
        bus.SC_LevelShiftCtrl_win_InLow = 1'b1;
        chk_state("adv2", 2'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc();
        chk_state("load2", 2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        run_shifts("run_l2", 6, 2, 2);             // k=5: counter = 1 = last
        // Win coincides with a tick: pulse must be suppressed
        bus.SC_LevelShiftCtrl_win_InLow = 1'b0;
        cyc();
        bus.SC_LevelShiftCtrl_win_InLow = 1'b1;
        chk_state("adv3", 2'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc();
        chk_state("load3", 2'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        run_shifts("run_l3", 6, 2, 2);
        bus.SC_LevelShiftCtrl_win_InLow = 1'b0;
        cyc();
        bus.SC_LevelShiftCtrl_win_InLow = 1'b1;
        chk_state("won", 2'd3, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk_state("won_hold", 2'd3, 1'b1, 1'b1, 1'b0, 1'b1);
        end

        // Restart from WON
        bus.SC_LevelShiftCtrl_start_InLow = 1'b0;
        cyc();
        bus.SC_LevelShiftCtrl_start_InLow = 1'b1;
        chk_state("won_restart", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        run_shifts("run_r0", 5, 4, 4);
        bus.SC_LevelShiftCtrl_win_InLow = 1'b0;
        cyc();
        bus.SC_LevelShiftCtrl_win_InLow = 1'b1;
        chk_state("adv_r1", 2'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc();
        chk_state("load_r1", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        run_shifts("run_r1", 3, 3, 3);             // k=2: tick due

        // Win and lose together on a tick: lose wins, level kept, no pulse
        bus.SC_LevelShiftCtrl_win_InLow  = 1'b0;
        bus.SC_LevelShiftCtrl_lose_InLow = 1'b0;
        cyc();
        chk_state("over", 2'd1, 1'b1, 1'b1, 1'b1, 1'b0);
        bus.SC_LevelShiftCtrl_lose_InLow = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk_state("over_hold", 2'd1, 1'b1, 1'b1, 1'b1, 1'b0);
        end
        bus.SC_LevelShiftCtrl_win_InLow = 1'b1;

        // Restart from OVER: back to level 0 at period 4
        bus.SC_LevelShiftCtrl_start_InLow = 1'b0;
        cyc();
        bus.SC_LevelShiftCtrl_start_InLow = 1'b1;
        chk_state("over_restart", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        run_shifts("run_o0", 5, 4, 4);

        // Climb to level 2, then reset mid-RUN
        bus.SC_LevelShiftCtrl_win_InLow = 1'b0;
        cyc();
        bus.SC_LevelShiftCtrl_win_InLow = 1'b1;
        cyc();
        chk_state("load_o1", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc();
        bus.SC_LevelShiftCtrl_win_InLow = 1'b0;
        cyc();
        bus.SC_LevelShiftCtrl_win_InLow = 1'b1;
        chk_state("adv_o2", 2'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc();
        run_shifts("run_o2", 4, 2, 2);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk_state("rst_run", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Reset during LOAD
        bus.SC_LevelShiftCtrl_start_InLow = 1'b0;
        cyc();
        chk_state("load_pre_rst", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bus.SC_LevelShiftCtrl_start_InLow = 1'b1;
        chk_state("rst_load", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc();
        chk_state("idle_after", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sc_level_shift_ctrl.md
SC_LEVEL_SHIFT_CTRL -- requirements
Module: sc_level_shift_ctrl

Interface
REQ-001 Parameters, one per line (name, default, meaning):
  TICKS_L1, 24'd5000000, clocks between shift pulses at level 1 (legal 2..2^24-1)
  TICKS_L2, 24'd3750000, same, level 2
  TICKS_L3, 24'd2500000, same, level 3
  TICKS_L4, 24'd1250000, same, level 4
  SHIFT_DIR, 2'b01, shift code issued on a tick (2'b01 rotate left, 2'b10 rotate right)
REQ-002 Ports, one per line (name, direction, width, meaning):
  SC_LevelShiftCtrl_CLOCK_50  in  1  sole clock, rising edge
  SC_LevelShiftCtrl_RESET_InHigh  in  1  synchronous active-high reset
  SC_LevelShiftCtrl_start_InLow  in  1  start/restart request
  SC_LevelShiftCtrl_win_InLow  in  1  frog reached goal row
  SC_LevelShiftCtrl_lose_InLow  in  1  frog collision
  SC_LevelShiftCtrl_pause_InLow  in  1  freeze lane motion
  SC_LevelShiftCtrl_level_OutBUS  out  2  level index 0..3, drives background-register transition selector
  SC_LevelShiftCtrl_clear_OutLow  out  1  background-register clear
  SC_LevelShiftCtrl_load_OutLow  out  1  background-register load
  SC_LevelShiftCtrl_shiftselection_Out  out  2  background-register shift code
  SC_LevelShiftCtrl_gameover_OutHigh  out  1  game lost
  SC_LevelShiftCtrl_gamewon_OutHigh  out  1  all four levels cleared
REQ-003 One clock; reset synchronous, active-high; no other clock or asynchronous input path.

Function
REQ-004 FSM states: IDLE, LOAD, RUN, ADVANCE, OVER, WON; all outputs registered (change only on clock edge).
REQ-005 IDLE: clear_OutLow=0, level=0; start_InLow==0 -> LOAD next cycle.
REQ-006 LOAD: exactly one cycle, load_OutLow=0, tick counter=0; -> RUN.
REQ-007 RUN: counter increments each cycle when pause_InLow==1; on counter==TICKS_Lx-1 (x=level+1): shiftselection_Out=SHIFT_DIR for exactly one cycle, counter -> 0.
REQ-008 First shift pulse appears TICKS_Lx cycles after first RUN cycle; shiftselection_Out=2'b00 in every other cycle and state.
REQ-009 pause_InLow==0 in RUN: counter holds, no pulse; resuming continues from held count.
REQ-010 RUN priority: lose > win > pause > tick; lose_InLow==0 -> OVER; win_InLow==0 -> ADVANCE if level<3, else WON; win/lose honoured while paused.
REQ-011 Tick coinciding with win or lose: pulse suppressed.
REQ-012 ADVANCE: one cycle, level increments by 1 (no wrap possible), -> LOAD.
REQ-013 OVER: gameover_OutHigh=1; WON: gamewon_OutHigh=1; both hold until start_InLow==0, then level=0, -> LOAD.
REQ-014 start/win/lose ignored in states not listing them; inputs are level-sampled, not edge-detected.
REQ-015 Counter 24 bits unsigned; never exceeds TICKS_Lx-1.
REQ-016 Inactive values: clear_OutLow=1, load_OutLow=1, gameover=0, gamewon=0 except as stated.

Reset
REQ-017 RESET_InHigh==1 at clock edge: state=IDLE, level=0, counter=0, clear_OutLow=0, load_OutLow=1, shiftselection_Out=2'b00, gameover=0, gamewon=0.
REQ-018 Reset overrides every input and every state, including mid-RUN and mid-LOAD.

Structure
REQ-019 Shared package holds state encoding, SHIFT_LEFT=2'b01, SHIFT_RIGHT=2'b10, SHIFT_NONE=2'b00, level codes 0..3, counter width 24.
REQ-020 One sub-module, sc_shift_tick: 24-bit period counter with clear, enable, period input, one-cycle tick output.

Verification (TICKS_L1..L4 = 4,3,2,2; SHIFT_DIR=2'b01)
REQ-021 Reset then start low 1 cycle -> load_OutLow low exactly 1 cycle, level=0, first shiftselection=01 4 cycles after RUN entry, then every 4 cycles.
REQ-022 win low in RUN at levels 0,1,2 -> ADVANCE, level 1,2,3, load pulse each time; tick period 3,2,2; win at level 3 -> gamewon=1, no further shifts.
REQ-023 win and lose low same cycle -> gameover=1, level unchanged, no shift pulse that cycle.
REQ-024 pause low 10 cycles at counter=2, level 0 -> no pulses during pause; next pulse 2 cycles after release.
REQ-025 Reset high mid-RUN at level 2 -> next cycle IDLE, level=0, clear_OutLow=0, shiftselection=00.
REQ-026 gameover set, start low -> gameover=0, level=0, load pulse, run resumes at 4-cycle period.
